int_arbiter: RTL

Multi-source machine-external interrupt controller placed between the external interrupt pins and the CPU trap logic. Synchronises and edge-detects each source, latches pending bits, and arbitrates by fixed priority (lowest index wins). Presents one request with a source ID to the CPU and tracks the claim/complete handshake, so only one external interrupt is in service at a time.

---
 rtl/int_arbiter_if.sv | 40 ++++
 rtl/int_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/int_arbiter_if.sv
// ----------------------------------------------------------------------------
// int_arbiter_if
// CPU-side request/claim/complete handshake of the external interrupt arbiter.
//
// Signals:
//   g_interrupt   arbiter -> cpu  registered interrupt request
//   int_id        arbiter -> cpu  ID of the requested / in-service source
//   busy          arbiter -> cpu  arbiter is not idle
//   int_ack       cpu -> arbiter  one-cycle claim pulse (trap taken)
//   int_complete  cpu -> arbiter  one-cycle completion pulse (mret)
//
// Modports:
//   master  the arbiter (drives the request)
//   slave   the CPU trap logic (answers the request)
// ----------------------------------------------------------------------------
interface int_arbiter_if #(
    parameter int unsigned ID_W = 2
) ();
    logic            g_interrupt;
    logic [ID_W-1:0] int_id;
    logic            busy;
    logic            int_ack;
    logic            int_complete;

    modport master (
        output g_interrupt,
        output int_id,
        output busy,
        input  int_ack,
        input  int_complete
    );

    modport slave (
        input  g_interrupt,
        input  int_id,
        input  busy,
        output int_ack,
        output int_complete
    );
endinterface

// File: rtl/int_arbiter.sv
// ----------------------------------------------------------------------------
// int_arbiter
// Machine-external interrupt controller between the external interrupt pins
// and the CPU trap logic. Each source is synchronised (3 flops) and
// rising-edge detected into a pending bit. Pending sources that are enabled
// are arbitrated by fixed priority (lowest index wins) and presented to the
// CPU as one registered request plus source ID. A claim/complete handshake
// keeps exactly one external interrupt in service at a time.
//
// Parameters:
//   NUM_SRC  number of interrupt sources (1..8)
//   ID_W     width of int_id, NUM_SRC <= 2**ID_W
//   TIMEOUT  REQ cycles without a claim before the request is withdrawn
//            (only with INT_CLAIM_TIMEOUT_EN)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   int_src     raw level interrupt inputs, asynchronous to clk
//   src_enable  per-source enable mask
//   csr_meie    global machine external interrupt enable
//   pending     pending bits for CSR readback
//   cpu         handshake interface (master side): g_interrupt, int_id, busy
//               out; int_ack, int_complete in
//
// Build option:
//   INT_CLAIM_TIMEOUT_EN  when defined, a request left unclaimed for TIMEOUT
//                         REQ cycles is withdrawn and re-arbitrated.
// ----------------------------------------------------------------------------
module int_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic [NUM_SRC-1:0] src_enable,
    input  logic               csr_meie,
    output logic [NUM_SRC-1:0] pending,
    int_arbiter_if.master      cpu
);

    if (NUM_SRC < 1 || NUM_SRC > 8 || NUM_SRC > (32'd1 << ID_W) || TIMEOUT < 1)
    begin : gen_param_check
        $error("int_arbiter: unsupported NUM_SRC/ID_W/TIMEOUT combination");
    end

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } state_e;

    logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] id_onehot;
    logic [NUM_SRC-1:0] clr_mask;
    logic [ID_W-1:0]    winner;
    logic               id_enabled;
    logic               claim;

    state_e             state_q;
    logic               g_int_q;
    logic [ID_W-1:0]    id_q;

`ifdef INT_CLAIM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CntW-1:0] cnt_q;
`endif

    // Input synchroniser; sync3 is only the previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= int_src;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign src_edge = sync2_q & ~sync3_q;
    assign eligible = pending_q & src_enable;

    // Lowest index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            id_onehot[i] = (id_q == ID_W'(i));
        end
    end

    assign id_enabled = |(src_enable & id_onehot);
    assign claim      = (state_q == StReq) && cpu.int_ack;
    assign clr_mask   = claim ? id_onehot : '0;
    // A new edge on the claimed source must not be lost: set beats clear.
    assign pending_d  = (pending_q & ~clr_mask) | src_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            g_int_q <= 1'b0;
            id_q    <= '0;
`ifdef INT_CLAIM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (csr_meie && (|eligible)) begin
                        id_q    <= winner;
                        g_int_q <= 1'b1;
                        state_q <= StReq;
`ifdef INT_CLAIM_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                StReq: begin
                    // Claim wins over a same-cycle withdrawal.
                    if (cpu.int_ack) begin
                        g_int_q <= 1'b0;
                        state_q <= StService;
                    end else if (!csr_meie || !id_enabled) begin
                        g_int_q <= 1'b0;
                        state_q <= StIdle;
                    end
`ifdef INT_CLAIM_TIMEOUT_EN
                    else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        g_int_q <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
`endif
                end
                StService: begin
                    if (cpu.int_complete) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    g_int_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cpu.g_interrupt = g_int_q;
    assign cpu.int_id      = id_q;
    assign cpu.busy        = (state_q != StIdle);
    assign pending         = pending_q;

endmodule
